// File: rtl/demux_16to1_collector_if.sv
// rtl/demux_16to1_collector_if.sv - strobe collector request/grant interface
interface demux_16to1_collector_if;
    logic [15:0] REQ;
    logic        READY;
    logic        CLR_OVR;
    logic        VALID;
    logic [3:0]  S;
    logic [15:0] PENDING;
    logic [15:0] OVERRUN;

    modport master (
        output REQ, READY, CLR_OVR,
        input  VALID, S, PENDING, OVERRUN
    );

    modport slave (
        input  REQ, READY, CLR_OVR,
        output VALID, S, PENDING, OVERRUN
    );
endinterface

// File: rtl/demux_16to1_collector.sv
// rtl/demux_16to1_collector.sv - folds 16 channel strobes into one arbitrated select stream
module demux_16to1_collector #(
    parameter bit         ROUND_ROBIN = 1'b1,
    parameter logic [3:0] RESET_PTR   = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    demux_16to1_collector_if.slave   bus
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t      state_q, state_d;
    logic [3:0]  s_q, s_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] overrun_q, overrun_d;
    logic [15:0] grant_clr;
    logic [15:0] remaining;
    logic        handshake;

    // First set bit scanning upward from start (mod 16); fixed mode always scans from 0.
    function automatic logic [3:0] select_ch(input logic [15:0] mask, input logic [3:0] start);
        logic [3:0] base;
        logic [3:0] idx;
        logic [3:0] sel;
        base = ROUND_ROBIN ? start : 4'd0;
        sel  = base;
        for (int k = 15; k >= 0; k--) begin
            idx = base + 4'(k);
            if (mask[idx]) sel = idx;
        end
        return sel;
    endfunction

    always_comb begin
        handshake = (state_q == OFFER) && bus.READY;
        grant_clr = handshake ? (16'd1 << s_q) : 16'd0;
        remaining = pending_q & ~(16'd1 << s_q);
        // A new strobe on the channel being granted re-arms it: set wins over clear.
        pending_d = (pending_q & ~grant_clr) | bus.REQ;
        overrun_d = (overrun_q & ~{16{bus.CLR_OVR}}) | (bus.REQ & pending_q & ~grant_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= 4'd0;
            ptr_q     <= RESET_PTR;
            pending_q <= 16'd0;
            overrun_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d = OFFER;
                    s_d     = select_ch(pending_q, ptr_q);
                end
            end
            OFFER: begin
                if (bus.READY) begin
                    ptr_d = s_q + 4'd1;
                    if (|remaining) begin
                        s_d = select_ch(remaining, s_q + 4'd1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.VALID   = (state_q == OFFER);
        bus.S       = s_q;
        bus.PENDING = pending_q;
        bus.OVERRUN = overrun_q;
    end

endmodule

// File: tb/tb_demux_16to1_collector.sv
// tb/tb_demux_16to1_collector.sv - table, directed and random checks for demux_16to1_collector
module tb_demux_16to1_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        ready;
    logic        clr_ovr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_16to1_collector_if rr_if();
    demux_16to1_collector_if fp_if();

    assign rr_if.REQ     = req;
    assign rr_if.READY   = ready;
    assign rr_if.CLR_OVR = clr_ovr;
    assign fp_if.REQ     = req;
    assign fp_if.READY   = ready;
    assign fp_if.CLR_OVR = clr_ovr;

    demux_16to1_collector #(.ROUND_ROBIN(1'b1), .RESET_PTR(4'd0)) dut_rr (
        .clk(clk), .rst(rst), .bus(rr_if.slave)
    );

    demux_16to1_collector #(.ROUND_ROBIN(1'b0), .RESET_PTR(4'd0)) dut_fp (
        .clk(clk), .rst(rst), .bus(fp_if.slave)
    );

    // Reference state: index 0 = round-robin instance, index 1 = fixed-priority instance.
    logic [15:0] m_pend[2];
    logic [15:0] m_ovr[2];
    logic        m_valid[2];
    int          m_s[2];
    int          m_ptr[2];

    typedef struct {
        logic        r;
        logic [15:0] q;
        logic        rd;
        logic        c;
        logic        ev;
        logic [3:0]  es;
        logic [15:0] ep;
        logic [15:0] eo;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] mask, input int start, input bit rr);
        int b;
        b = rr ? start : 0;
        for (int k = 0; k < 16; k++) begin
            if (mask[(b + k) % 16]) return (b + k) % 16;
        end
        return 0;
    endfunction

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit          rr;
            bit          hs;
            logic [15:0] np;
            logic [15:0] no;
            logic [15:0] rem;
            rr = (m == 0);
            hs = m_valid[m] && ready;
            for (int i = 0; i < 16; i++) begin
                bit granted;
                granted = hs && (m_s[m] == i);
                np[i]  = (m_pend[m][i] && !granted) || req[i];
                no[i]  = (m_ovr[m][i] && !clr_ovr) || (req[i] && m_pend[m][i] && !granted);
                rem[i] = m_pend[m][i] && (m_s[m] != i);
            end
            if (rst) begin
                m_pend[m] = 16'd0; m_ovr[m] = 16'd0; m_valid[m] = 1'b0; m_s[m] = 0; m_ptr[m] = 0;
            end else begin
                if (!m_valid[m]) begin
                    if (m_pend[m] != 16'd0) begin
                        m_s[m] = pick(m_pend[m], m_ptr[m], rr);
                        m_valid[m] = 1'b1;
                    end
                end else if (ready) begin
                    m_ptr[m] = (m_s[m] + 1) % 16;
                    if (rem != 16'd0) m_s[m] = pick(rem, m_ptr[m], rr);
                    else m_valid[m] = 1'b0;
                end
                m_pend[m] = np;
                m_ovr[m]  = no;
            end
        end
    endtask

    task automatic compare_model();
        check("rr.VALID",   32'(rr_if.VALID),   32'(m_valid[0]));
        check("rr.S",       32'(rr_if.S),       32'(m_s[0]));
        check("rr.PENDING", 32'(rr_if.PENDING), 32'(m_pend[0]));
        check("rr.OVERRUN", 32'(rr_if.OVERRUN), 32'(m_ovr[0]));
        check("fp.VALID",   32'(fp_if.VALID),   32'(m_valid[1]));
        check("fp.S",       32'(fp_if.S),       32'(m_s[1]));
        check("fp.PENDING", 32'(fp_if.PENDING), 32'(m_pend[1]));
        check("fp.OVERRUN", 32'(fp_if.OVERRUN), 32'(m_ovr[1]));
    endtask

    task automatic drive(input logic r, input logic [15:0] q, input logic rd, input logic c);
        rst = r; req = q; ready = rd; clr_ovr = c;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 16'd0; m_ovr[m] = 16'd0; m_valid[m] = 1'b0; m_s[m] = 0; m_ptr[m] = 0;
        end
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0);

        // Expected values are round-robin outputs just after the edge on which the row is applied.
        tbl[0]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 16'h0020, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0020, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd5, 16'h0020, 16'h0000};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b0, 16'h0101, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0101, 16'h0000};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0101, 16'h0000};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0101, 16'h0000};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0101, 16'h0000};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0101, 16'h0000};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0101, 16'h0000};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd8, 16'h0100, 16'h0000};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd8, 16'h0000, 16'h0000};

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].q, tbl[i].rd, tbl[i].c);
            tick();
            check($sformatf("tbl%0d.VALID", i),   32'(rr_if.VALID),   32'(tbl[i].ev));
            check($sformatf("tbl%0d.S", i),       32'(rr_if.S),       32'(tbl[i].es));
            check($sformatf("tbl%0d.PENDING", i), 32'(rr_if.PENDING), 32'(tbl[i].ep));
            check($sformatf("tbl%0d.OVERRUN", i), 32'(rr_if.OVERRUN), 32'(tbl[i].eo));
        end

        // Round-robin wrap: grant 14, then 15 -> 0 -> 1 back to back.
        drive(1'b1, 16'h0000, 1'b1, 1'b0); tick();
        drive(1'b0, 16'h4000, 1'b1, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        check("wrap.S14", 32'(rr_if.S), 32'd14);
        drive(1'b0, 16'h8003, 1'b1, 1'b0); tick();
        check("wrap.idle", 32'(rr_if.VALID), 32'd0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        check("wrap.S15", {31'd0, rr_if.VALID} << 4 | 32'(rr_if.S), 32'h1F);
        tick();
        check("wrap.S0",  {31'd0, rr_if.VALID} << 4 | 32'(rr_if.S), 32'h10);
        tick();
        check("wrap.S1",  {31'd0, rr_if.VALID} << 4 | 32'(rr_if.S), 32'h11);
        tick();
        check("wrap.end", 32'(rr_if.VALID), 32'd0);

        // Overrun, set-wins on handshake, and clear.
        drive(1'b1, 16'h0000, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0008, 1'b0, 1'b0); tick();
        check("ovr.none", 32'(rr_if.OVERRUN), 32'h0);
        drive(1'b0, 16'h0008, 1'b0, 1'b0); tick();
        check("ovr.set", 32'(rr_if.OVERRUN), 32'h0008);
        drive(1'b0, 16'h0008, 1'b1, 1'b0); tick();
        check("ovr.setwins.pend", 32'(rr_if.PENDING), 32'h0008);
        check("ovr.setwins.ovr",  32'(rr_if.OVERRUN), 32'h0008);
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        check("ovr.regrant", {31'd0, rr_if.VALID} << 4 | 32'(rr_if.S), 32'h13);
        tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b1); tick();
        check("ovr.clr", 32'(rr_if.OVERRUN), 32'h0);
        drive(1'b0, 16'h0001, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0001, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0001, 1'b0, 1'b1); tick();
        check("ovr.clr_vs_set", 32'(rr_if.OVERRUN), 32'h0001);
        drive(1'b0, 16'h0000, 1'b1, 1'b1); tick();
        check("ovr.clr2", 32'(rr_if.OVERRUN), 32'h0);
        tick(); tick();

        // Fixed priority order 0, 14, 15 and reset during an offer.
        drive(1'b1, 16'h0000, 1'b1, 1'b0); tick();
        drive(1'b0, 16'hC001, 1'b1, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        check("fix.S0",  {31'd0, fp_if.VALID} << 4 | 32'(fp_if.S), 32'h10);
        tick();
        check("fix.S14", {31'd0, fp_if.VALID} << 4 | 32'(fp_if.S), 32'h1E);
        tick();
        check("fix.S15", {31'd0, fp_if.VALID} << 4 | 32'(fp_if.S), 32'h1F);
        tick();
        check("fix.end", 32'(fp_if.VALID), 32'd0);
        drive(1'b0, 16'h0001, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0); tick();
        check("fix.offer", 32'(fp_if.VALID), 32'd1);
        drive(1'b1, 16'h0000, 1'b0, 1'b0); tick();
        check("fix.rst.valid", 32'(fp_if.VALID), 32'd0);
        check("fix.rst.pend",  32'(fp_if.PENDING), 32'd0);

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'($urandom)) : 16'd0,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 31) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
